// File: rtl/rx_packet_deframer_pkg.sv
// Shared deframer definitions: FSM encodings, packet geometry, sync word, counter helpers.
// RX_SYNC_TOLERANT_EN additionally brings in the popcount used by the tolerant sync compare.
package rx_packet_deframer_pkg;

  localparam int          PACKET_BITS            = 288;
  localparam logic [15:0] SYNC_WORD_DEFAULT      = 16'hA5C3;
  localparam int          TIMEOUT_CYCLES_DEFAULT = 1024;
  localparam int          CNT_W                  = 16;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_DONE    = 2'b10
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 16'd1;
  endfunction

`ifdef RX_SYNC_TOLERANT_EN
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction
`endif

endpackage

// File: rtl/rx_packet_deframer_if.sv
// Bitstream-in / packet-out bundle between the photodiode sampler, the deframer and its consumers.
interface rx_packet_deframer_if;
  import rx_packet_deframer_pkg::*;

  logic                   rx_bit;
  logic                   rx_valid;
  logic [PACKET_BITS-1:0] packet;
  logic                   ready;
  logic                   busy;
  logic [CNT_W-1:0]       frames_ok;
  logic [CNT_W-1:0]       frames_dropped;

  modport master (
    output rx_bit, rx_valid,
    input  packet, ready, busy, frames_ok, frames_dropped
  );

  modport slave (
    input  rx_bit, rx_valid,
    output packet, ready, busy, frames_ok, frames_dropped
  );

endinterface

// File: rtl/rx_packet_deframer_sync_detector.sv
// 16-bit sync shift register with combinational match on the post-shift value.
// RX_SYNC_TOLERANT_EN: accept a Hamming distance of at most one; otherwise exact equality.
module rx_packet_deframer_sync_detector
  import rx_packet_deframer_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en_i,
  input  logic bit_i,
  input  logic clear_i,
  output logic match_o
);

  logic [15:0] sr_q, sr_d;
  logic [15:0] shifted;
  logic        hit;

  assign shifted = {sr_q[14:0], bit_i};

`ifdef RX_SYNC_TOLERANT_EN
  // Exact match is a subset of this test, so it is never detected later.
  assign hit = (popcount16(shifted ^ SYNC_WORD) <= 5'd1);
`else
  assign hit = (shifted == SYNC_WORD);
`endif

  assign match_o = shift_en_i && hit;

  always_comb begin
    sr_d = sr_q;
    if (clear_i) begin
      sr_d = '0;
    end else if (shift_en_i) begin
      sr_d = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/rx_packet_deframer.sv
// Hunts for the sync word, assembles one 288-bit MSB-first packet, pulses ready, aborts on strobe timeout.
// RX_SYNC_TOLERANT_EN selects the one-bit-error-tolerant sync compare inside the detector.
module rx_packet_deframer
  import rx_packet_deframer_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
  parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  rx_packet_deframer_if.slave  bus
);

  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]        BIT_LAST = 9'(PACKET_BITS - 1);

  state_e                 state_q, state_d;
  logic [PACKET_BITS-1:0] asm_q, asm_d;
  logic [PACKET_BITS-1:0] pkt_q, pkt_d;
  logic [8:0]             bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       ok_q, ok_d;
  logic [CNT_W-1:0]       drop_q, drop_d;

  logic sync_shift, sync_clear, sync_match;

  // DONE keeps feeding the sync register so hunting never has a blind cycle.
  assign sync_shift = bus.rx_valid && ((state_q == ST_HUNT) || (state_q == ST_DONE));
  assign sync_clear = sync_match && (state_q == ST_HUNT);

  rx_packet_deframer_sync_detector #(
    .SYNC_WORD (SYNC_WORD)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .shift_en_i (sync_shift),
    .bit_i      (bus.rx_bit),
    .clear_i    (sync_clear),
    .match_o    (sync_match)
  );

  always_comb begin
    state_d   = state_q;
    asm_d     = asm_q;
    pkt_d     = pkt_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    ok_d      = ok_q;
    drop_d    = drop_q;

    case (state_q)
      ST_HUNT: begin
        if (sync_match) begin
          state_d   = ST_COLLECT;
          bit_cnt_d = '0;
          tmo_d     = '0;
        end
      end
      ST_COLLECT: begin
        if (bus.rx_valid) begin
          asm_d     = {asm_q[PACKET_BITS-2:0], bus.rx_bit};
          bit_cnt_d = bit_cnt_q + 9'd1;
          tmo_d     = '0;
          if (bit_cnt_q == BIT_LAST) begin
            pkt_d   = asm_d;
            state_d = ST_DONE;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Abandoned frame: packet keeps the last good contents.
          state_d = ST_HUNT;
          drop_d  = sat_inc(drop_q);
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_HUNT;
        ok_d    = sat_inc(ok_q);
      end
      default: state_d = ST_HUNT;
    endcase

    ready_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_HUNT;
      asm_q     <= '0;
      pkt_q     <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      ready_q   <= 1'b0;
      ok_q      <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      asm_q     <= asm_d;
      pkt_q     <= pkt_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      ready_q   <= ready_d;
      ok_q      <= ok_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.packet         = pkt_q;
  assign bus.ready          = ready_q;
  assign bus.busy           = (state_q == ST_COLLECT);
  assign bus.frames_ok      = ok_q;
  assign bus.frames_dropped = drop_q;

endmodule

// File: tb/tb_rx_packet_deframer.sv
// Directed bench for rx_packet_deframer: frame vector table plus timeout and mid-frame reset sequences.
module tb_rx_packet_deframer;
  import rx_packet_deframer_pkg::*;

`ifdef RX_SYNC_TOLERANT_EN
  localparam bit TOL = 1'b1;
`else
  localparam bit TOL = 1'b0;
`endif

  typedef struct {
    logic [15:0]  sync;
    logic [287:0] payload;
    int           gap;
    bit           accept;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rx_packet_deframer_if bus ();

  rx_packet_deframer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int ready_cnt = 0;

  always @(negedge clk) begin
    if (bus.ready === 1'b1) ready_cnt++;
  end

  logic [287:0] pat_p;
  logic [287:0] pat_q;
  logic [287:0] pat_s;
  vec_t         vecs[5];

  task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_bit   = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_bit   = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word16(input logic [15:0] w, input int gap);
    for (int i = 15; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic send_payload(input logic [287:0] p, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) send_bit(p[287-i], (i == nbits - 1) ? 0 : gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_bit   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_packet"},  bus.packet, 288'd0);
    chk({tag, "_ready"},   288'(bus.ready), 288'd0);
    chk({tag, "_busy"},    288'(bus.busy), 288'd0);
    chk({tag, "_ok"},      288'(bus.frames_ok), 288'd0);
    chk({tag, "_dropped"}, 288'(bus.frames_dropped), 288'd0);
  endtask

  // Sync, payload, then the cycle after ready; counters checked against absolute expectations.
  task automatic run_vec(input string tag, input logic [15:0] sw, input logic [287:0] pl,
                         input int gap, input bit acc, input int ok_before,
                         input int drop_exp, input logic [287:0] pkt_before);
    int r0;
    r0 = ready_cnt;
    send_word16(sw, gap);
    chk({tag, "_busy_after_sync"}, 288'(bus.busy), 288'(acc));
    send_payload(pl, PACKET_BITS, gap);
    chk({tag, "_ready_at_last"}, 288'(bus.ready), 288'(acc));
    chk({tag, "_packet"}, bus.packet, acc ? pl : pkt_before);
    chk({tag, "_busy_at_ready"}, 288'(bus.busy), 288'd0);
    @(negedge clk);
    chk({tag, "_ready_after"}, 288'(bus.ready), 288'd0);
    chk({tag, "_frames_ok"}, 288'(bus.frames_ok), 288'(ok_before + int'(acc)));
    chk({tag, "_frames_dropped"}, 288'(bus.frames_dropped), 288'(drop_exp));
    chk({tag, "_ready_pulses"}, 288'(ready_cnt - r0), 288'(int'(acc)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_bit   = 1'b0;

    pat_p = 288'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123CDEF;
    pat_q = {36{8'h11}};
    pat_s = '0;
    pat_s[247:232] = 16'hA5C3;

    vecs[0] = '{sync: 16'hA5C3, payload: pat_p, gap: 0, accept: 1'b1};
    vecs[1] = '{sync: 16'hA5C3, payload: pat_p, gap: 6, accept: 1'b1};
    vecs[2] = '{sync: 16'hA5C3, payload: pat_s, gap: 0, accept: 1'b1};
    vecs[3] = '{sync: 16'hA5C2, payload: pat_q, gap: 0, accept: TOL};
    vecs[4] = '{sync: 16'hA5C0, payload: pat_q, gap: 0, accept: 1'b0};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      chk_zero($sformatf("v%0d_rst", i));
      run_vec($sformatf("v%0d", i), vecs[i].sync, vecs[i].payload, vecs[i].gap,
              vecs[i].accept, 0, 0, 288'd0);
    end

    // Timeout after 100 bits: still collecting near the limit, aborted shortly after it.
    begin
      int r0;
      do_reset();
      run_vec("to_pre", 16'hA5C3, pat_p, 0, 1'b1, 0, 0, 288'd0);
      r0 = ready_cnt;
      send_word16(16'hA5C3, 0);
      chk("to_busy_after_sync", 288'(bus.busy), 288'd1);
      send_payload(pat_p, 100, 0);
      repeat (1000) @(negedge clk);
      chk("to_busy_before_limit", 288'(bus.busy), 288'd1);
      chk("to_dropped_before_limit", 288'(bus.frames_dropped), 288'd0);
      repeat (30) @(negedge clk);
      chk("to_busy_after_limit", 288'(bus.busy), 288'd0);
      chk("to_dropped", 288'(bus.frames_dropped), 288'd1);
      chk("to_packet_kept", bus.packet, pat_p);
      chk("to_frames_ok", 288'(bus.frames_ok), 288'd1);
      chk("to_no_ready", 288'(ready_cnt - r0), 288'd0);
      run_vec("to_post", 16'hA5C3, pat_q, 0, 1'b1, 1, 1, pat_p);
    end

    // Single-cycle reset after 150 payload bits clears everything without a drop.
    begin
      do_reset();
      run_vec("mr_pre", 16'hA5C3, pat_q, 0, 1'b1, 0, 0, 288'd0);
      send_word16(16'hA5C3, 0);
      send_payload(pat_p, 150, 0);
      chk("mr_busy_mid", 288'(bus.busy), 288'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_zero("mr_after_rst");
      run_vec("mr_post", 16'hA5C3, pat_p, 0, 1'b1, 0, 0, 288'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
